// File: rtl/gfx_cmd_pkg.sv
// rtl/gfx_cmd_pkg.sv - shared opcodes, frame lengths and tx state type for gfx_cmd_tx
// Purpose: constants and types common to the draw-command transmitter.
// Ports: none (package).
package gfx_cmd_pkg;

  localparam logic [7:0] OP_LINE  = 8'h4C;
  localparam logic [7:0] OP_POINT = 8'h50;

  // Parameter bytes following the opcode, and seed bytes closing a line.
  localparam int POINT_PARAMS = 3;
  localparam int LINE_PARAMS  = 5;
  localparam int SEED_BYTES   = 2;

  // Whole-frame lengths; a line frame adds PAD_CYCLES filler bytes.
  localparam int POINT_FRAME_LEN  = 1 + POINT_PARAMS;
  localparam int LINE_FRAME_FIXED = 1 + LINE_PARAMS + SEED_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_PARAM,
    ST_PAD,
    ST_SEED,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/gfx_ep_order.sv
// rtl/gfx_ep_order.sv - combinational compare-and-swap of line endpoints
// Purpose: when en is high and x0 > x1, swaps (x0,y0) with (x1,y1) so the
//          start point has the smaller x; otherwise passes endpoints through.
// Ports: en (swap permitted), x0_i/y0_i/x1_i/y1_i (raw endpoints),
//        x0_o/y0_o/x1_o/y1_o (ordered endpoints).
module gfx_ep_order (
  input  logic       en,
  input  logic [7:0] x0_i,
  input  logic [7:0] y0_i,
  input  logic [7:0] x1_i,
  input  logic [7:0] y1_i,
  output logic [7:0] x0_o,
  output logic [7:0] y0_o,
  output logic [7:0] x1_o,
  output logic [7:0] y1_o
);

  logic swap;

  assign swap = en && (x0_i > x1_i);
  assign x0_o = swap ? x1_i : x0_i;
  assign y0_o = swap ? y1_i : y0_i;
  assign x1_o = swap ? x0_i : x1_i;
  assign y1_o = swap ? y0_i : y1_i;

endmodule

// File: rtl/gfx_cmd_tx.sv
// rtl/gfx_cmd_tx.sv - serialises point/line draw requests into a CCU command byte stream
// Purpose: accepts one draw request at a time and emits its frame on cmd, one
//          byte per clk: point = 50,X,Y,C; line = 4C,Xs,Ys,Xe,Ye,C,pads,Xs,Ys.
//          Optional macro GFX_CMD_TX_ORDER_EN: lines are reordered so Xs <= Xe.
// Ports: clk, rst_n (sync active-low); req_valid/req_ready handshake with
//        req_line, req_x0, req_y0, req_x1, req_y1, req_colour; cmd (byte out),
//        cmd_active (frame byte on cmd), frame_done (last byte of a frame).
module gfx_cmd_tx
  import gfx_cmd_pkg::*;
#(
  parameter int         PAD_CYCLES = 5,
  parameter int         GAP_CYCLES = 1,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_line,
  input  logic [7:0] req_x0,
  input  logic [7:0] req_y0,
  input  logic [7:0] req_x1,
  input  logic [7:0] req_y1,
  input  logic [7:0] req_colour,
  output logic [7:0] cmd,
  output logic       cmd_active,
  output logic       frame_done
);

  localparam logic [7:0] PAD_N     = 8'(PAD_CYCLES);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] PT_LAST   = 8'(POINT_PARAMS - 1);
  localparam logic [7:0] LN_LAST   = 8'(LINE_PARAMS - 1);
  localparam logic [7:0] SEED_LAST = 8'(SEED_BYTES - 1);

  tx_state_t  state_q, state_d, after_frame;
  logic [7:0] cnt_q, cnt_d;
  logic       line_q, line_d;
  logic [7:0] xs_q, xs_d, ys_q, ys_d, xe_q, xe_d, ye_q, ye_d, col_q, col_d;
  logic [7:0] ox0, oy0, ox1, oy1;
  logic       accept;

`ifdef GFX_CMD_TX_ORDER_EN
  gfx_ep_order u_ep_order (
    .en   (req_line),
    .x0_i (req_x0),
    .y0_i (req_y0),
    .x1_i (req_x1),
    .y1_i (req_y1),
    .x0_o (ox0),
    .y0_o (oy0),
    .x1_o (ox1),
    .y1_o (oy1)
  );
`else
  assign ox0 = req_x0;
  assign oy0 = req_y0;
  assign ox1 = req_x1;
  assign oy1 = req_y1;
`endif

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    col_d   = col_q;
    // With no gap the frame's last cycle doubles as the acceptance cycle.
    after_frame = ST_GAP;
    if (GAP_CYCLES == 0) after_frame = accept ? ST_OPC : ST_IDLE;
    // req_ready is only high in IDLE or on a zero-gap last byte, so capture
    // never disturbs a frame in flight.
    if (accept) begin
      line_d = req_line;
      xs_d   = ox0;
      ys_d   = oy0;
      xe_d   = ox1;
      ye_d   = oy1;
      col_d  = req_colour;
    end
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_OPC;
      ST_OPC: begin
        state_d = ST_PARAM;
        cnt_d   = '0;
      end
      ST_PARAM: begin
        if (cnt_q == (line_q ? LN_LAST : PT_LAST)) begin
          cnt_d = '0;
          if (!line_q) state_d = after_frame;
          else if (PAD_CYCLES > 0) begin
            state_d = ST_PAD;
            cnt_d   = PAD_N;
          end else state_d = ST_SEED;
        end else cnt_d = cnt_q + 8'd1;
      end
      // Pads count down to 1 so the counter never passes through zero.
      ST_PAD: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_SEED;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 8'd1;
      end
      ST_SEED: begin
        if (cnt_q == SEED_LAST) begin
          state_d = after_frame;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd        = IDLE_BYTE;
    cmd_active = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_OPC: begin
        cmd        = line_q ? OP_LINE : OP_POINT;
        cmd_active = 1'b1;
      end
      ST_PARAM: begin
        cmd_active = 1'b1;
        case (cnt_q)
          8'd0:    cmd = xs_q;
          8'd1:    cmd = ys_q;
          8'd2:    cmd = line_q ? xe_q : col_q;
          8'd3:    cmd = ye_q;
          default: cmd = col_q;
        endcase
        frame_done = !line_q && (cnt_q == PT_LAST);
      end
      ST_PAD: cmd_active = 1'b1;
      ST_SEED: begin
        cmd        = (cnt_q == 8'd0) ? xs_q : ys_q;
        cmd_active = 1'b1;
        frame_done = (cnt_q == SEED_LAST);
      end
      default: ;
    endcase
    req_ready = (state_q == ST_IDLE) || ((GAP_CYCLES == 0) && frame_done);
  end

endmodule
